// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and TX entry layout for the SPI byte queue
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_XFER   = 2'd2
    } state_t;

    // TX entry layout: {capture, end_txn, dc, data[7:0]}
    localparam int TX_W    = 11;
    localparam int TX_CAP  = 10;
    localparam int TX_END  = 9;
    localparam int TX_DC   = 8;
    localparam int LEVEL_W = 5;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and registered storage
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/spi_byte_queue.sv
// rtl/spi_byte_queue.sv - TX/RX byte queues feeding the SPI byte controller start/busy handshake
module spi_byte_queue
    import spi_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    input  logic               wr_dc,
    input  logic               wr_end_txn,
    input  logic               wr_capture,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    input  logic               rd_pop,
    output logic [LEVEL_W-1:0] tx_level,
    output logic               rx_overflow,
    input  logic               clear_overflow,
    output logic               idle,
    output logic               ctrl_start,
    output logic [7:0]         ctrl_data,
    output logic               ctrl_dc,
    output logic               ctrl_end_txn,
    input  logic               ctrl_busy,
    input  logic [7:0]         ctrl_data_out
);

    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;

    state_t r_state;
    state_t w_state_nxt;

    logic            r_start;
    logic [7:0]      r_data;
    logic            r_dc;
    logic            r_end_txn;
    logic            r_capture;
    logic            r_overflow;

    logic [TX_W-1:0]  w_tx_entry;
    logic [TX_W-1:0]  w_tx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [TX_LW-1:0] w_tx_level;
    logic             w_tx_pop;
    logic             w_launch;

    logic [7:0]       w_rx_head;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [RX_LW-1:0] w_rx_level;
    logic             w_rx_push;
    logic             w_rx_drop;
    logic             w_unused_rx_level;

    assign w_tx_entry = {wr_capture, wr_end_txn, wr_dc, wr_data};

    spi_sync_fifo #(
        .WIDTH (TX_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_valid),
        .i_data  (w_tx_entry),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_level (w_tx_level)
    );

    spi_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (ctrl_data_out),
        .i_pop   (rd_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_level (w_rx_level)
    );

    assign w_unused_rx_level = ^w_rx_level;

    // Start is issued only from S_IDLE, so waiting in S_LAUNCH for a late busy cannot double-launch.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        w_launch    = 1'b0;
        w_rx_push   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_tx_empty && !ctrl_busy) begin
                    w_tx_pop    = 1'b1;
                    w_launch    = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (ctrl_busy) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (!ctrl_busy) begin
                    w_rx_push   = r_capture;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pop at full frees the slot, so only an unpopped full RX drops the byte.
    assign w_rx_drop = w_rx_push && w_rx_full && !rd_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_data     <= 8'h00;
            r_dc       <= 1'b0;
            r_end_txn  <= 1'b0;
            r_capture  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_launch;
            if (w_launch) begin
                r_data    <= w_tx_head[7:0];
                r_dc      <= w_tx_head[TX_DC];
                r_end_txn <= w_tx_head[TX_END];
                r_capture <= w_tx_head[TX_CAP];
            end
            if (w_rx_drop)
                r_overflow <= 1'b1;
            else if (clear_overflow)
                r_overflow <= 1'b0;
        end
    end

    assign wr_ready     = !w_tx_full;
    assign rd_valid     = !w_rx_empty;
    assign rd_data      = w_rx_head;
    assign tx_level     = LEVEL_W'(w_tx_level);
    assign rx_overflow  = r_overflow;
    assign idle         = w_tx_empty && (r_state == S_IDLE);
    assign ctrl_start   = r_start;
    assign ctrl_data    = r_data;
    assign ctrl_dc      = r_dc;
    assign ctrl_end_txn = r_end_txn;

endmodule

// File: tb/tb_spi_byte_queue.sv
// tb/tb_spi_byte_queue.sv - directed self-checking bench for spi_byte_queue with a behavioural controller
module tb_spi_byte_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_dc;
    logic       wr_end_txn;
    logic       wr_capture;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_pop;
    logic [4:0] tx_level;
    logic       rx_overflow;
    logic       clear_overflow;
    logic       idle;
    logic       ctrl_start;
    logic [7:0] ctrl_data;
    logic       ctrl_dc;
    logic       ctrl_end_txn;
    logic       ctrl_busy;
    logic [7:0] ctrl_data_out;

    logic       m_busy;
    logic       hold = 1'b0;
    int         busy_len = 4;
    int         busy_dly = 0;
    logic [7:0] resp_xor = 8'h00;
    int         m_phase;
    int         m_cnt;
    int         dup_starts = 0;
    logic [7:0] log_data[$];
    logic       log_dc[$];
    logic       log_end[$];
    logic [4:0] log_level[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign ctrl_busy = m_busy | hold;

    spi_byte_queue #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_dc          (wr_dc),
        .wr_end_txn     (wr_end_txn),
        .wr_capture     (wr_capture),
        .wr_ready       (wr_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_pop         (rd_pop),
        .tx_level       (tx_level),
        .rx_overflow    (rx_overflow),
        .clear_overflow (clear_overflow),
        .idle           (idle),
        .ctrl_start     (ctrl_start),
        .ctrl_data      (ctrl_data),
        .ctrl_dc        (ctrl_dc),
        .ctrl_end_txn   (ctrl_end_txn),
        .ctrl_busy      (ctrl_busy),
        .ctrl_data_out  (ctrl_data_out)
    );

    initial forever #5 clk = ~clk;

    // Controller model runs on the falling edge so the DUT never races it on the rising edge.
    initial begin
        m_busy        = 1'b0;
        m_phase       = 0;
        m_cnt         = 0;
        ctrl_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy  = 1'b0;
                m_phase = 0;
                m_cnt   = 0;
            end else begin
                if (ctrl_start && (m_phase != 0 || ctrl_busy)) dup_starts++;
                case (m_phase)
                    0: if (ctrl_start) begin
                        log_data.push_back(ctrl_data);
                        log_dc.push_back(ctrl_dc);
                        log_end.push_back(ctrl_end_txn);
                        log_level.push_back(tx_level);
                        ctrl_data_out = ctrl_data ^ resp_xor;
                        if (busy_dly == 0) begin
                            m_busy  = 1'b1;
                            m_cnt   = busy_len;
                            m_phase = 2;
                        end else begin
                            m_cnt   = busy_dly;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            m_busy  = 1'b1;
                            m_cnt   = busy_len;
                            m_phase = 2;
                        end
                    end
                    default: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            m_busy  = 1'b0;
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic dc, input logic e, input logic cap);
        wr_valid   = 1'b1;
        wr_data    = d;
        wr_dc      = dc;
        wr_end_txn = e;
        wr_capture = cap;
        step();
        wr_valid   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(idle && !ctrl_busy) && n < 500) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 500), 32'd1);
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_dc.delete();
        log_end.delete();
        log_level.delete();
        dup_starts = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        int  k;
        logic prev_busy;
        rst = 1'b1;
        wr_valid = 1'b0; wr_data = 8'h00; wr_dc = 1'b0; wr_end_txn = 1'b0; wr_capture = 1'b0;
        rd_pop = 1'b0; clear_overflow = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_idle", idle, 1);
        check("rst_start", ctrl_start, 0);
        check("rst_overflow", rx_overflow, 0);
        check("rst_ctrl_data", ctrl_data, 8'h00);

        // single byte with capture, response 0xA5^0x99 = 0x3C
        busy_len = 16; resp_xor = 8'h99; clear_logs();
        push(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_idle("t1");
        check("t1_starts", log_data.size(), 1);
        check("t1_data", log_data[0], 8'hA5);
        check("t1_dc", log_dc[0], 1);
        check("t1_end", log_end[0], 1);
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_data", rd_data, 8'h3C);
        check("t1_idle", idle, 1);
        rd_pop = 1'b1; step(); rd_pop = 1'b0;
        check("t1_rd_empty", rd_valid, 0);

        // burst of four, no capture
        busy_len = 4; resp_xor = 8'h00; clear_logs();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(8'(i + 1), 1'b0, 1'b0, 1'b0);
            check($sformatf("t2_fill_level%0d", i), tx_level, 32'(i + 1));
        end
        hold = 1'b0;
        wait_idle("t2");
        check("t2_starts", log_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i), log_data[i], 32'(i + 1));
            check($sformatf("t2_level%0d", i), log_level[i], 32'(3 - i));
        end
        check("t2_dup", dup_starts, 0);
        check("t2_rx_empty", rd_valid, 0);
        check("t2_hold_data", ctrl_data, 8'h04);

        // TX full: fifth push ignored, push+pop at full accepted
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        check("t3_level_full", tx_level, 4);
        check("t3_wr_ready", wr_ready, 0);
        hold = 1'b0;
        wr_valid = 1'b1; wr_data = 8'h25; wr_capture = 1'b0;
        step();
        wr_valid = 1'b0;
        check("t3_pushpop_level", tx_level, 4);
        wait_idle("t3");
        check("t3_starts", log_data.size(), 5);
        check("t3_d0", log_data[0], 8'h20);
        check("t3_d3", log_data[3], 8'h23);
        check("t3_d4", log_data[4], 8'h25);

        // RX overflow
        busy_len = 2; clear_logs();
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
            wait_idle($sformatf("t4_send%0d", i));
            if (i == 3) check("t4_no_ovf", rx_overflow, 0);
        end
        check("t4_ovf", rx_overflow, 1);
        clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
        check("t4_cleared", rx_overflow, 0);
        push(8'h15, 1'b0, 1'b0, 1'b1);
        prev_busy = 1'b0;
        k = 0;
        while (k < 100) begin
            @(negedge clk); #1;
            if (prev_busy && !ctrl_busy) break;
            prev_busy = ctrl_busy;
            k++;
        end
        check("t4_fall_timeout", 32'(k < 100), 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("t4_set_wins", rx_overflow, 1);
        wait_idle("t4_last");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_rx%0d", i), rd_data, 32'(8'h10 + i));
            rd_pop = 1'b1; step(); rd_pop = 1'b0;
        end
        check("t4_rx_empty", rd_valid, 0);
        rd_pop = 1'b1; step(); rd_pop = 1'b0;
        check("t4_pop_empty", rd_valid, 0);
        check("t4_pop_empty_ovf", rx_overflow, 1);

        // reset mid-transfer with two entries queued
        busy_len = 20; clear_logs();
        push(8'h30, 1'b0, 1'b0, 1'b1);
        push(8'h31, 1'b0, 1'b0, 1'b1);
        push(8'h32, 1'b0, 1'b0, 1'b1);
        repeat (5) step();
        check("t5_pre_level", tx_level, 2);
        check("t5_pre_busy", ctrl_busy, 1);
        rst = 1'b1;
        #1;
        check("t5_level", tx_level, 0);
        check("t5_rd_valid", rd_valid, 0);
        check("t5_start", ctrl_start, 0);
        check("t5_idle", idle, 1);
        check("t5_ctrl_data", ctrl_data, 8'h00);
        check("t5_ovf", rx_overflow, 0);
        step(); step();
        rst = 1'b0;
        n = log_data.size();
        repeat (20) step();
        check("t5_no_start", log_data.size(), n);
        check("t5_idle_after", idle, 1);

        // slow busy rise
        busy_len = 4; busy_dly = 3; clear_logs();
        push(8'h40, 1'b0, 1'b1, 1'b1);
        wait_idle("t6");
        check("t6_starts", log_data.size(), 1);
        check("t6_dup", dup_starts, 0);
        check("t6_rd_data", rd_data, 8'h40);
        check("t6_end", log_end[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
